// File: rtl/hc_tester_pkg.sv
// Shared definitions for the HC02 bring-up tester.
//   state_e : tester sequencing states
//   VEC_W   : vector index width (A and B packed together)
//   ERR_W   : failing-vector counter width (holds 0..256)
//   Y_W     : gate count of the quad NOR
//   nor_exp : reference NOR for one vector
package hc_tester_pkg;

  localparam int VEC_W = 8;
  localparam int ERR_W = 9;
  localparam int Y_W   = 4;

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, FINISH} state_e;

  function automatic logic [Y_W-1:0] nor_exp(input logic [Y_W-1:0] a,
                                             input logic [Y_W-1:0] b);
    return ~(a | b);
  endfunction

endpackage

// File: rtl/hc_sync2.sv
// Two-flop synchronizer, width-parameterized, async active-low reset.
//   gclk   : destination clock
//   grst_n : async reset, flops load RST_VAL
//   d      : asynchronous input
//   q      : synchronized output (two gclk edges of latency)
module hc_sync2 #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         gclk,
  input  logic         grst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/hc02_tester.sv
// Exhaustive self-checking driver for a 74HC02 quad NOR.
// On START, walks all 256 A/B combinations, holds each for a settle time,
// compares Y against the expected NOR and reports per-vector failures.
//   CLK, RST_N   : clock, async active-low reset
//   START        : run request (ignored while BUSY)
//   Y            : NOR outputs returned from the device under test
//   A, B         : NOR inputs, A = vec[3:0], B = vec[7:4] (registered)
//   BUSY, DONE   : run in progress / run complete (held until next START)
//   PASS         : DONE with no failing vectors
//   ERR_CNT      : number of failing vectors
//   FAIL_VALID   : a failing vector has been captured
//   FIRST_FAIL   : index of the first failing vector
// Build option HC02_TESTER_SYNC_EN: Y goes through a two-flop synchronizer
// (for an external chip); each vector is then held two cycles longer.
module hc02_tester
  import hc_tester_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [Y_W:1]     Y,
  output logic [Y_W:1]     A,
  output logic [Y_W:1]     B,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_CNT,
  output logic             FAIL_VALID,
  output logic [VEC_W-1:0] FIRST_FAIL
);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("hc02_tester: SETTLE_CYCLES must be at least 1");
  end

  // Counter load: the SETTLE state runs load+1 cycles, CHECK adds one more.
`ifdef HC02_TESTER_SYNC_EN
  localparam int SETTLE_LOAD = SETTLE_CYCLES + 1;
`else
  localparam int SETTLE_LOAD = SETTLE_CYCLES - 1;
`endif
  localparam int                CNT_W = $clog2(SETTLE_CYCLES + 2);
  localparam logic [CNT_W-1:0]  LOAD  = CNT_W'(SETTLE_LOAD);

  state_e           state, nstate;
  logic [VEC_W-1:0] vec;
  logic [CNT_W-1:0] cnt;
  logic [Y_W:1]     y_cmp;
  logic             start_acc;
  logic             mismatch;
  logic             last_vec;

`ifdef HC02_TESTER_SYNC_EN
  hc_sync2 #(.W(Y_W), .RST_VAL('1)) u_ysync (
    .gclk   (CLK),
    .grst_n (RST_N),
    .d      (Y),
    .q      (y_cmp)
  );
`else
  assign y_cmp = Y;
`endif

  assign A          = vec[3:0];
  assign B          = vec[7:4];
  assign PASS       = DONE && (ERR_CNT == '0);
  assign last_vec   = (vec == '1);
  assign mismatch   = (y_cmp != nor_exp(vec[3:0], vec[7:4]));
  // FINISH has BUSY low, so a START there begins a fresh run at once.
  assign start_acc  = START && ((state == IDLE) || (state == FINISH));

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (start_acc) nstate = SETTLE;
      SETTLE:  if (cnt == '0) nstate = CHECK;
      CHECK:   nstate = last_vec ? FINISH : SETTLE;
      FINISH:  nstate = start_acc ? SETTLE : IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vec        <= '0;
      cnt        <= '0;
      BUSY       <= 1'b0;
      DONE       <= 1'b0;
      ERR_CNT    <= '0;
      FAIL_VALID <= 1'b0;
      FIRST_FAIL <= '0;
    end else if (start_acc) begin
      vec        <= '0;
      cnt        <= LOAD;
      BUSY       <= 1'b1;
      DONE       <= 1'b0;
      ERR_CNT    <= '0;
      FAIL_VALID <= 1'b0;
      FIRST_FAIL <= '0;
    end else begin
      case (state)
        SETTLE: if (cnt != '0) cnt <= cnt - CNT_W'(1);
        CHECK: begin
          if (mismatch) begin
            ERR_CNT <= ERR_CNT + ERR_W'(1);
            if (!FAIL_VALID) begin
              FAIL_VALID <= 1'b1;
              FIRST_FAIL <= vec;
            end
          end
          // BUSY falls and DONE rises on the edge leaving the last CHECK.
          if (last_vec) begin
            BUSY <= 1'b0;
            DONE <= 1'b1;
          end else begin
            vec <= vec + VEC_W'(1);
            cnt <= LOAD;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
